// File: rtl/rx_pkt_pkg.sv
// rx_pkt_pkg: shared definitions for the RX packet path (assembler and packetizer).
//   - Default packet geometry (words per packet, header words, payload sample slots).
//   - Control-block header field positions: payload length (bytes) and overrun flag.
//   - FSM state encoding and the payload-length to sample-count helper.
package rx_pkt_pkg;

    localparam int unsigned PktWordsDefault = 256;
    localparam int unsigned HdrWordsDefault = 4;
    localparam int unsigned MaxSampsDefault = 252;

    localparam int unsigned WordW = 16;
    localparam int unsigned HdrW  = 64;
    localparam int unsigned IdxW  = 9;

    // Header field positions, shared with the packetizer that builds the header.
    localparam int unsigned CbPayloadLenLo = 0;
    localparam int unsigned CbPayloadLenHi = 8;
    localparam int unsigned CbOverrunBit   = 15;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StHdr  = 2'd1,
        StData = 2'd2,
        StPad  = 2'd3
    } rx_state_e;

    // Two bytes per sample; an odd trailing byte is dropped, then clamp to the slot count.
    function automatic logic [IdxW-1:0] samp_count(input logic [8:0] len_bytes,
                                                   input int unsigned max_samps);
        logic [IdxW-1:0] samps;
        samps = {1'b0, len_bytes[8:1]};
        if ({23'd0, samps} > max_samps) begin
            return IdxW'(max_samps);
        end
        return samps;
    endfunction

endpackage

// File: rtl/rx_hdr_serializer.sv
// rx_hdr_serializer: holds one 64-bit packet header and presents it 16 bits at a time.
// Ports:
//   clk_i    - clock, rising edge
//   reset_i  - synchronous active-high reset, clears the held header
//   load_i   - capture hdr_i this cycle
//   hdr_i    - header word from the header fifo
//   sel_i    - word select, 0 selects bits [15:0]
//   word_o   - selected 16-bit header word
module rx_hdr_serializer
    import rx_pkt_pkg::*;
(
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [HdrW-1:0]  hdr_i,
    input  logic [1:0]       sel_i,
    output logic [WordW-1:0] word_o
);

    logic [HdrW-1:0] hdr_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            hdr_q <= '0;
        end else if (load_i) begin
            hdr_q <= hdr_i;
        end
    end

    always_comb begin
        word_o = hdr_q[{sel_i, 4'b0000} +: WordW];
    end

endmodule

// File: rtl/rx_packet_assembler.sv
// rx_packet_assembler: builds fixed-length packets of PKT_WORDS 16-bit words from a header
// fifo and a channel-data fifo (both show-ahead). Each packet is HDR_WORDS header words,
// up to MAX_SAMPS samples (payload length / 2, clamped), then zero padding.
// Ports:
//   rdclk, reset           - clock and synchronous active-high reset
//   ph_empty/ph_data/ph_rdreq - header fifo interface
//   cd_empty/cd_data/cd_rdreq - channel data fifo interface
//   out_rdy/out_valid/out_data/out_sop/out_eop - packet word stream (valid/ready)
//   busy                   - packet in progress
// Optional feature (macro RX_PKT_STATS_EN): adds pkt_count and ovr_count outputs.
module rx_packet_assembler
    import rx_pkt_pkg::*;
#(
    parameter int unsigned PKT_WORDS = PktWordsDefault,
    parameter int unsigned HDR_WORDS = HdrWordsDefault,
    parameter int unsigned MAX_SAMPS = MaxSampsDefault
) (
    input  logic             rdclk,
    input  logic             reset,
    input  logic             ph_empty,
    input  logic [HdrW-1:0]  ph_data,
    output logic             ph_rdreq,
    input  logic             cd_empty,
    input  logic [WordW-1:0] cd_data,
    output logic             cd_rdreq,
    input  logic             out_rdy,
    output logic             out_valid,
    output logic [WordW-1:0] out_data,
    output logic             out_sop,
    output logic             out_eop,
    output logic             busy
`ifdef RX_PKT_STATS_EN
    ,
    output logic [15:0]      pkt_count,
    output logic [15:0]      ovr_count
`endif
);

    localparam logic [IdxW-1:0] LastIdx    = IdxW'(PKT_WORDS - 1);
    localparam logic [IdxW-1:0] LastHdrIdx = IdxW'(HDR_WORDS - 1);

    rx_state_e       state_q, state_d;
    logic [IdxW-1:0] idx_q, idx_d;
    logic [IdxW-1:0] samp_left_q, samp_left_d;
    logic            hdr_load;
    logic            last_word;
    logic [WordW-1:0] hdr_word;

    rx_hdr_serializer u_hdr_ser (
        .clk_i   (rdclk),
        .reset_i (reset),
        .load_i  (hdr_load),
        .hdr_i   (ph_data),
        .sel_i   (idx_q[1:0]),
        .word_o  (hdr_word)
    );

    always_ff @(posedge rdclk) begin
        if (reset) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            samp_left_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            samp_left_q <= samp_left_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        samp_left_d = samp_left_q;
        hdr_load    = 1'b0;
        ph_rdreq    = 1'b0;
        cd_rdreq    = 1'b0;
        out_valid   = 1'b0;
        out_data    = '0;
        out_sop     = 1'b0;
        last_word   = (idx_q == LastIdx);

        case (state_q)
            StIdle: begin
                // Pops are gated by reset so a reset cycle never consumes fifo entries.
                if (!ph_empty && !reset) begin
                    ph_rdreq    = 1'b1;
                    hdr_load    = 1'b1;
                    samp_left_d = samp_count(ph_data[CbPayloadLenHi:CbPayloadLenLo], MAX_SAMPS);
                    idx_d       = '0;
                    state_d     = StHdr;
                end
            end
            StHdr: begin
                out_valid = 1'b1;
                out_data  = hdr_word;
                out_sop   = (idx_q == '0);
                if (out_rdy) begin
                    idx_d = idx_q + 1'b1;
                    if (idx_q == LastHdrIdx) begin
                        state_d = (samp_left_q != '0) ? StData : StPad;
                    end
                end
            end
            StData: begin
                out_valid = !cd_empty;
                out_data  = cd_data;
                cd_rdreq  = !cd_empty && out_rdy && !reset;
                if (!cd_empty && out_rdy) begin
                    samp_left_d = samp_left_q - 1'b1;
                    // A full payload ends exactly on the last word, so skip PAD entirely.
                    if (last_word) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                        if (samp_left_q == IdxW'(1)) begin
                            state_d = StPad;
                        end
                    end
                end
            end
            StPad: begin
                out_valid = 1'b1;
                if (out_rdy) begin
                    if (last_word) begin
                        state_d = StIdle;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        out_eop = out_valid && last_word;
    end

    assign busy = (state_q != StIdle);

`ifdef RX_PKT_STATS_EN
    logic [15:0] pkt_count_q;
    logic [15:0] ovr_count_q;

    always_ff @(posedge rdclk) begin
        if (reset) begin
            pkt_count_q <= '0;
            ovr_count_q <= '0;
        end else begin
            if (out_valid && out_rdy && out_eop) begin
                pkt_count_q <= pkt_count_q + 16'd1;
            end
            if (hdr_load && ph_data[CbOverrunBit]) begin
                ovr_count_q <= ovr_count_q + 16'd1;
            end
        end
    end

    assign pkt_count = pkt_count_q;
    assign ovr_count = ovr_count_q;
`endif

endmodule

// File: tb/tb_rx_packet_assembler.sv
module tb_rx_packet_assembler;

    logic        rdclk = 1'b0;
    logic        reset;
    logic        ph_empty, ph_rdreq, cd_empty, cd_rdreq;
    logic [63:0] ph_data;
    logic [15:0] cd_data, out_data;
    logic        out_rdy, out_valid, out_sop, out_eop, busy;
`ifdef RX_PKT_STATS_EN
    logic [15:0] pkt_count, ovr_count;
`endif

    rx_packet_assembler dut (
        .rdclk     (rdclk),
        .reset     (reset),
        .ph_empty  (ph_empty),
        .ph_data   (ph_data),
        .ph_rdreq  (ph_rdreq),
        .cd_empty  (cd_empty),
        .cd_data   (cd_data),
        .cd_rdreq  (cd_rdreq),
        .out_rdy   (out_rdy),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .busy      (busy)
`ifdef RX_PKT_STATS_EN
        ,
        .pkt_count (pkt_count),
        .ovr_count (ovr_count)
`endif
    );

    always #5 rdclk = ~rdclk;

    logic [63:0] hq[$];
    logic [15:0] dq[$];
    logic [15:0] cap[$];
    logic [15:0] expq[$];
    int sop_pos[$], eop_pos[$], sop_cyc[$], eop_cyc[$];
    int checks, errors, cyc, cd_pops, viol;
    bit rdy_toggle, stall_armed;
    int force_cnt;
    bit prev_stall, prev_cde;
    logic [15:0] prev_data;
    logic snap_valid, snap_sop, snap_eop, snap_ph, snap_cd, snap_busy;
    logic [15:0] snap_data;

    function automatic void drive_inputs();
        ph_empty = (hq.size() == 0);
        ph_data  = (hq.size() != 0) ? hq[0] : 64'h0;
        if (stall_armed && cd_pops == 100) begin
            force_cnt   = 5;
            stall_armed = 1'b0;
        end
        cd_empty = (force_cnt > 0) || (dq.size() == 0);
        if (force_cnt > 0) force_cnt--;
        cd_data = (dq.size() != 0) ? dq[0] : 16'h0;
    endfunction

    function automatic void clear_cap();
        cap.delete(); expq.delete();
        sop_pos.delete(); eop_pos.delete(); sop_cyc.delete(); eop_cyc.delete();
        cd_pops = 0; viol = 0; prev_stall = 1'b0;
    endfunction

    function automatic void build_exp(input logic [63:0] hdr, input int nsamp,
                                      input logic [15:0] base);
        for (int i = 0; i < 4; i++) expq.push_back(hdr[16*i +: 16]);
        for (int i = 0; i < nsamp; i++) expq.push_back(base + 16'(i));
        for (int i = 4 + nsamp; i < 256; i++) expq.push_back(16'h0000);
    endfunction

    // One clock: sample outputs on the falling edge, then apply fifo pops and new inputs
    // just after the rising edge.
    task automatic step();
        bit do_ph, do_cd;
        @(negedge rdclk);
        cyc++;
        snap_valid = out_valid; snap_sop = out_sop; snap_eop = out_eop; snap_data = out_data;
        snap_ph = ph_rdreq; snap_cd = cd_rdreq; snap_busy = busy;
        if (cd_rdreq && cd_empty) viol++;
        if (ph_rdreq && (ph_empty || busy)) viol++;
        if (prev_stall && prev_cde == cd_empty && (out_valid !== 1'b1 || out_data !== prev_data))
            viol++;
        if (out_valid && out_rdy) begin
            if (out_sop) begin sop_pos.push_back(cap.size()); sop_cyc.push_back(cyc); end
            if (out_eop) begin eop_pos.push_back(cap.size()); eop_cyc.push_back(cyc); end
            cap.push_back(out_data);
        end
        prev_stall = out_valid && !out_rdy;
        prev_data  = out_data;
        prev_cde   = cd_empty;
        do_ph = ph_rdreq;
        do_cd = cd_rdreq;
        @(posedge rdclk);
        #1;
        if (do_ph && hq.size() != 0) void'(hq.pop_front());
        if (do_cd && dq.size() != 0) begin void'(dq.pop_front()); cd_pops++; end
        out_rdy = rdy_toggle ? !out_rdy : 1'b1;
        drive_inputs();
    endtask

    task automatic run_pkts(input int n, input int budget, output bit ok);
        int k = 0;
        while (eop_pos.size() < n && k < budget) begin step(); k++; end
        ok = (eop_pos.size() >= n);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        hq.push_back(64'h0000_0000_0000_0010);
        drive_inputs();
        repeat (3) step();
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", snap_valid); end
        checks++; if (snap_sop !== 1'b0) begin errors++; $display("FAIL reset_sop: got %b want 0", snap_sop); end
        checks++; if (snap_eop !== 1'b0) begin errors++; $display("FAIL reset_eop: got %b want 0", snap_eop); end
        checks++; if (snap_data !== 16'h0) begin errors++; $display("FAIL reset_data: got %h want 0000", snap_data); end
        checks++; if (snap_ph !== 1'b0) begin errors++; $display("FAIL reset_ph_rdreq: got %b want 0", snap_ph); end
        checks++; if (snap_cd !== 1'b0) begin errors++; $display("FAIL reset_cd_rdreq: got %b want 0", snap_cd); end
        checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", snap_busy); end
        checks++; if (hq.size() != 1) begin errors++; $display("FAIL reset_no_pop: hdr fifo depth %0d want 1", hq.size()); end
        hq.delete();
        reset = 1'b0;
        drive_inputs();
        repeat (2) step();
        checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", snap_busy); end
    endtask

    task automatic test_full();
        logic [63:0] h = 64'hD004_C003_B002_01F8;  // len 504 -> 252 samples
        bit ok; int mism = 0, first = -1;
        clear_cap();
        hq.push_back(h);
        for (int i = 0; i < 252; i++) dq.push_back(16'h1000 + 16'(i));
        build_exp(h, 252, 16'h1000);
        drive_inputs();
        run_pkts(1, 400, ok);
        step();
        checks++; if (!ok) begin errors++; $display("FAIL full_timeout: eops %0d want 1", eop_pos.size()); end
        for (int i = 0; i < expq.size(); i++)
            if (i >= cap.size() || cap[i] !== expq[i]) begin if (first < 0) first = i; mism++; end
        checks++;
        if (mism != 0 || cap.size() != 256) begin
            errors++; $display("FAIL full_words: %0d bad (first %0d), got %0d words want 256", mism, first, cap.size());
        end
        checks++; if (sop_pos.size() != 1 || sop_pos[0] != 0) begin errors++; $display("FAIL full_sop: count %0d want one at 0", sop_pos.size()); end
        checks++; if (eop_pos.size() != 1 || eop_pos[0] != 255) begin errors++; $display("FAIL full_eop: count %0d want one at 255", eop_pos.size()); end
        checks++; if (cd_pops != 252) begin errors++; $display("FAIL full_pops: got %0d want 252", cd_pops); end
        checks++; if (viol != 0) begin errors++; $display("FAIL full_protocol: %0d violations want 0", viol); end
        checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL full_idle: busy %b want 0", snap_busy); end
    endtask

    task automatic test_short();
        logic [63:0] h = 64'h4444_3333_2222_0014;  // len 20 -> 10 samples
        bit ok; int mism = 0, first = -1;
        clear_cap();
        hq.push_back(h);
        for (int i = 0; i < 15; i++) dq.push_back(16'h2000 + 16'(i));
        build_exp(h, 10, 16'h2000);
        drive_inputs();
        run_pkts(1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL short_timeout: eops %0d want 1", eop_pos.size()); end
        for (int i = 0; i < expq.size(); i++)
            if (i >= cap.size() || cap[i] !== expq[i]) begin if (first < 0) first = i; mism++; end
        checks++;
        if (mism != 0 || cap.size() != 256) begin
            errors++; $display("FAIL short_words: %0d bad (first %0d), got %0d words want 256", mism, first, cap.size());
        end
        checks++; if (cd_pops != 10) begin errors++; $display("FAIL short_pops: got %0d want 10", cd_pops); end
        checks++; if (dq.size() != 5) begin errors++; $display("FAIL short_left: fifo depth %0d want 5", dq.size()); end
        checks++; if (viol != 0) begin errors++; $display("FAIL short_protocol: %0d violations want 0", viol); end
        dq.delete();
        drive_inputs();
    endtask

    task automatic test_zero_clamp();
        logic [63:0] h0 = 64'h5555_6666_7777_0000;  // len 0
        logic [63:0] h1 = 64'h8888_9999_AAAA_01FF;  // len 511 -> 255, clamped to 252
        bit ok; int mism = 0, first = -1;
        clear_cap();
        hq.push_back(h0);
        for (int i = 0; i < 3; i++) dq.push_back(16'h6000 + 16'(i));
        build_exp(h0, 0, 16'h0);
        drive_inputs();
        run_pkts(1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL zero_timeout: eops %0d want 1", eop_pos.size()); end
        for (int i = 0; i < expq.size(); i++)
            if (i >= cap.size() || cap[i] !== expq[i]) begin if (first < 0) first = i; mism++; end
        checks++;
        if (mism != 0 || cap.size() != 256) begin
            errors++; $display("FAIL zero_words: %0d bad (first %0d), got %0d words want 256", mism, first, cap.size());
        end
        checks++; if (cd_pops != 0) begin errors++; $display("FAIL zero_pops: got %0d want 0", cd_pops); end
        dq.delete();
        clear_cap();
        mism = 0; first = -1;
        hq.push_back(h1);
        for (int i = 0; i < 260; i++) dq.push_back(16'h7000 + 16'(i));
        build_exp(h1, 252, 16'h7000);
        drive_inputs();
        run_pkts(1, 400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL clamp_timeout: eops %0d want 1", eop_pos.size()); end
        for (int i = 0; i < expq.size(); i++)
            if (i >= cap.size() || cap[i] !== expq[i]) begin if (first < 0) first = i; mism++; end
        checks++;
        if (mism != 0 || cap.size() != 256) begin
            errors++; $display("FAIL clamp_words: %0d bad (first %0d), got %0d words want 256", mism, first, cap.size());
        end
        checks++; if (cd_pops != 252) begin errors++; $display("FAIL clamp_pops: got %0d want 252", cd_pops); end
        checks++; if (dq.size() != 8) begin errors++; $display("FAIL clamp_left: fifo depth %0d want 8", dq.size()); end
        dq.delete();
        drive_inputs();
    endtask

    task automatic test_stall();
        logic [63:0] h = 64'h0102_0304_0506_01F8;
        bit ok; int mism = 0, first = -1;
        clear_cap();
        hq.push_back(h);
        for (int i = 0; i < 252; i++) dq.push_back(16'h3000 + 16'(i));
        build_exp(h, 252, 16'h3000);
        rdy_toggle  = 1'b1;
        stall_armed = 1'b1;
        drive_inputs();
        run_pkts(1, 1500, ok);
        rdy_toggle = 1'b0;
        step();
        checks++; if (!ok) begin errors++; $display("FAIL stall_timeout: eops %0d want 1", eop_pos.size()); end
        for (int i = 0; i < expq.size(); i++)
            if (i >= cap.size() || cap[i] !== expq[i]) begin if (first < 0) first = i; mism++; end
        checks++;
        if (mism != 0 || cap.size() != 256) begin
            errors++; $display("FAIL stall_words: %0d bad (first %0d), got %0d words want 256", mism, first, cap.size());
        end
        checks++; if (cd_pops != 252) begin errors++; $display("FAIL stall_pops: got %0d want 252", cd_pops); end
        checks++; if (viol != 0) begin errors++; $display("FAIL stall_protocol: %0d violations want 0", viol); end
        checks++; if (stall_armed) begin errors++; $display("FAIL stall_armed: data stall never applied, got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        logic [63:0] ha = 64'hA3A2_A1A0_0000_0004;  // 2 samples
        logic [63:0] hb = 64'hB3B2_B1B0_0000_8004;  // 2 samples, overrun flag set
        bit ok; int mism = 0, first = -1, gap;
        clear_cap();
        hq.push_back(ha);
        hq.push_back(hb);
        for (int i = 0; i < 4; i++) dq.push_back(16'h5000 + 16'(i));
        build_exp(ha, 2, 16'h5000);
        build_exp(hb, 2, 16'h5002);
        drive_inputs();
        run_pkts(2, 800, ok);
        checks++; if (!ok) begin errors++; $display("FAIL b2b_timeout: eops %0d want 2", eop_pos.size()); end
        for (int i = 0; i < expq.size(); i++)
            if (i >= cap.size() || cap[i] !== expq[i]) begin if (first < 0) first = i; mism++; end
        checks++;
        if (mism != 0 || cap.size() != 512) begin
            errors++; $display("FAIL b2b_words: %0d bad (first %0d), got %0d words want 512", mism, first, cap.size());
        end
        gap = (sop_cyc.size() >= 2 && eop_cyc.size() >= 1) ? sop_cyc[1] - eop_cyc[0] : -1;
        checks++; if (gap != 2) begin errors++; $display("FAIL b2b_gap: sop after eop by %0d cycles want 2", gap); end
        checks++;
        if (cap.size() < 257 || cap[256] !== 16'h8004) begin
            errors++; $display("FAIL b2b_overrun: hdr word0 %h want 8004", (cap.size() > 256) ? cap[256] : 16'hxxxx);
        end
        checks++; if (cd_pops != 4) begin errors++; $display("FAIL b2b_pops: got %0d want 4", cd_pops); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] h = 64'hFEED_FACE_CAFE_01F8;
        int k = 0;
        clear_cap();
        hq.push_back(h);
        for (int i = 0; i < 252; i++) dq.push_back(16'h4000 + 16'(i));
        drive_inputs();
        while (cap.size() < 130 && k < 400) begin step(); k++; end
        checks++; if (cap.size() != 130) begin errors++; $display("FAIL mid_reach: words %0d want 130", cap.size()); end
        checks++; if (cd_pops != 126) begin errors++; $display("FAIL mid_pops_before: got %0d want 126", cd_pops); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (snap_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", snap_valid); end
        checks++; if (snap_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", snap_busy); end
        checks++; if (snap_data !== 16'h0) begin errors++; $display("FAIL mid_data: got %h want 0000", snap_data); end
        checks++; if (snap_sop !== 1'b0 || snap_eop !== 1'b0) begin errors++; $display("FAIL mid_flags: sop %b eop %b want 0 0", snap_sop, snap_eop); end
        checks++; if (snap_cd !== 1'b0) begin errors++; $display("FAIL mid_cd_rdreq: got %b want 0", snap_cd); end
        repeat (5) step();
        checks++; if (cd_pops != 126) begin errors++; $display("FAIL mid_no_pops: got %0d want 126", cd_pops); end
        checks++; if (eop_pos.size() != 0) begin errors++; $display("FAIL mid_abandon: eops %0d want 0", eop_pos.size()); end
        dq.delete();
        drive_inputs();
    endtask

`ifdef RX_PKT_STATS_EN
    task automatic test_stats();
        bit ok;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        checks++; if (pkt_count !== 16'd0 || ovr_count !== 16'd0) begin errors++; $display("FAIL stats_reset: pkt %0d ovr %0d want 0 0", pkt_count, ovr_count); end
        clear_cap();
        hq.push_back(64'h0);
        hq.push_back(64'h0000_0000_0000_8000);
        hq.push_back(64'h0);
        drive_inputs();
        run_pkts(3, 1200, ok);
        step();
        checks++; if (!ok) begin errors++; $display("FAIL stats_timeout: eops %0d want 3", eop_pos.size()); end
        checks++; if (pkt_count !== 16'd3) begin errors++; $display("FAIL stats_pkt: got %0d want 3", pkt_count); end
        checks++; if (ovr_count !== 16'd1) begin errors++; $display("FAIL stats_ovr: got %0d want 1", ovr_count); end
    endtask
`endif

    initial begin
        checks = 0; errors = 0; cyc = 0; force_cnt = 0;
        rdy_toggle = 1'b0; stall_armed = 1'b0;
        reset = 1'b1; out_rdy = 1'b1;
        prev_data = 16'h0; prev_cde = 1'b0;
        clear_cap();
        drive_inputs();
        test_reset();
        test_full();
        test_short();
        test_zero_clamp();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef RX_PKT_STATS_EN
        test_stats();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rx_packet_assembler.md
RX_PACKET_ASSEMBLER -- requirements
Module: rx_packet_assembler

Interface
REQ-001 SHALL have parameters: PKT_WORDS, default 256, 16-bit words per output packet; HDR_WORDS, default 4, header words per packet; MAX_SAMPS, default 252, payload sample slots.
REQ-002 SHALL have ports: rdclk  in  1  sole clock, all logic on rising edge; reset  in  1  synchronous, active-high.
REQ-003 SHALL have ports: ph_empty  in  1  header fifo empty; ph_data  in  64  header fifo show-ahead output; ph_rdreq  out  1  header fifo pop.
REQ-004 SHALL have ports: cd_empty  in  1  channel data fifo empty; cd_data  in  16  data fifo show-ahead output; cd_rdreq  out  1  data fifo pop.
REQ-005 SHALL have ports: out_rdy  in  1  consumer ready; out_valid  out  1  word valid; out_data  out  16  packet word; out_sop  out  1  first word; out_eop  out  1  last word.
REQ-006 SHALL have port busy  out  1  packet in progress (state != IDLE).

Function
REQ-007 SHALL use states IDLE, HDR, DATA, PAD; a word transfers only when out_valid && out_rdy.
REQ-008 IDLE: when !ph_empty, latch ph_data and payload length (bytes, field `CB_PAYLOAD_LEN, 9 bits), assert ph_rdreq one cycle, go HDR next cycle.
REQ-009 Sample count SHALL be len>>1, clamped to MAX_SAMPS; odd byte lengths round down.
REQ-010 HDR: emit latched header as HDR_WORDS words, bits [15:0] first; out_sop on word 0 only; then DATA if sample count > 0, else PAD.
REQ-011 DATA: out_valid = !cd_empty; out_data = cd_data; cd_rdreq = out_valid && out_rdy; cd_empty SHALL stall without losing position.
REQ-012 After the last counted sample, go PAD; PAD emits 0x0000 until word index PKT_WORDS-1; go PAD->IDLE after that word.
REQ-013 out_eop SHALL assert on word index PKT_WORDS-1 only; every packet is exactly PKT_WORDS words.
REQ-014 out_rdy low SHALL hold out_data, out_valid, index constant; no fifo pops while stalled.
REQ-015 Word index counter SHALL be 9 bits, reset to 0 on entering HDR, never wrap mid-packet.
REQ-016 cd_rdreq SHALL never assert when cd_empty; ph_rdreq SHALL never assert when ph_empty or outside IDLE.
REQ-017 Back-to-back: !ph_empty at eop SHALL start next packet with one IDLE cycle (one bubble).
REQ-018 Header overrun bit SHALL pass through unmodified.

Reset
REQ-019 reset SHALL force IDLE, index 0, out_valid 0, out_sop 0, out_eop 0, out_data 0, ph_rdreq 0, cd_rdreq 0, busy 0, counters 0.
REQ-020 reset mid-packet SHALL abandon the packet with no further pops; the partially sent packet is not completed.

Configuration
REQ-021 With RX_PKT_STATS_EN defined, SHALL add outputs pkt_count[15:0] (+1 per eop transfer) and ovr_count[15:0] (+1 per latched header with `CB_OVERRUN set), both wrapping 0xFFFF->0.
REQ-022 Without RX_PKT_STATS_EN, those ports and counters SHALL not exist; all other behaviour is identical.

Structure
REQ-023 State encoding, PKT_WORDS/HDR_WORDS/MAX_SAMPS defaults, and the `CB_PAYLOAD_LEN/`CB_OVERRUN field ranges SHALL live in shared package rx_pkt_pkg, also used by the packetizer.
REQ-024 Sub-module rx_hdr_serializer (64-bit latch, 4-word mux by index) is natural; FSM and counters stay top-level.

Verification
REQ-025 Header len=504, 252 samples queued, out_rdy=1 -> 256 words, sop@0, eop@255, 252 pops, zero pad words.
REQ-026 Header len=20 -> 4 hdr + 10 samples + 242 zeros, cd_rdreq exactly 10 pulses.
REQ-027 len=0 -> HDR goes straight to PAD, 252 zeros, no cd pops; len=511 -> clamped to 252 samples.
REQ-028 cd_empty for 5 cycles at sample 100, out_rdy toggling 50% -> no duplicated/dropped samples, out_data stable while stalled.
REQ-029 Two headers queued -> second sop exactly 2 cycles after first eop transfer (one IDLE bubble).
REQ-030 reset asserted at word 130 -> next cycle all outputs at reset values, IDLE; with RX_PKT_STATS_EN, 3 packets, 1 overrun -> pkt_count=3, ovr_count=1.
